id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 in_valid / in_ready  in / out  1 / 1  decode-side handshake.
REQ-005 in_rs1, in_rs2, in_rd  in  5 each  register indices.
REQ-006 in_rs1_data, in_rs2_data, in_imm  in  XLEN each  register-file operands, sign-extended immediate.
REQ-007 in_use_imm, in_reg_write, in_mem_read  in  1 each  operand-2 select, writeback enable, load flag.
REQ-008 in_optype, in_funct3, in_funct7  in  7 / 3 / 7  opcode, funct3, funct7.
REQ-009 exmem_rd, memwb_rd  in  5 each; exmem_reg_write, memwb_reg_write  in  1 each; exmem_result, memwb_result  in  XLEN each  forwarding sources.
REQ-010 flush  in  1  kills the held instruction and any capture this cycle.
REQ-011 out_valid / out_ready  out / in  1 / 1  execute-side handshake.
REQ-012 data1, data2, store_data  out  XLEN each  forwarded ALU operands, forwarded rs2.
REQ-013 optype, ALUOp, funct7, rd  out  7 / 3 / 7 / 5; reg_write, mem_read  out  1 each.
REQ-014 bubble_count  out  16  saturating count of inserted load-use bubbles.

Function
REQ-015 A transfer in occurs on a rising edge with in_valid && in_ready && !flush; all in_* fields are registered; ALUOp takes in_funct3.
REQ-016 in_ready = (!out_valid || out_ready) && !hazard, combinational.
REQ-017 hazard = out_valid && mem_read && rd != 0 && (rd == in_rs1 || (rd == in_rs2 && !in_use_imm)); in_valid does not gate it.
REQ-018 If hazard and out_ready in the same cycle: held instruction leaves, out_valid = 0 next cycle (bubble), bubble_count += 1, saturating at 0xFFFF.
REQ-019 If out_valid && out_ready and no transfer in: out_valid clears next cycle.
REQ-020 If out_valid && !out_ready: all registered fields hold; in_ready = 0.
REQ-021 flush: out_valid = 0 next edge regardless of out_ready, in_valid or hazard; no capture; no bubble count.
REQ-022 Forwarded rs1 value: exmem_result if exmem_reg_write && exmem_rd == rs1 && rs1 != 0; else memwb_result if memwb_reg_write && memwb_rd == rs1 && rs1 != 0; else the registered rs1 data. rs2 uses the same rule.
REQ-023 EX/MEM forwarding takes priority over MEM/WB; x0 is never forwarded.
REQ-024 data1 = forwarded rs1; data2 = registered imm if use_imm, else forwarded rs2; store_data = forwarded rs2 always.
REQ-025 Forwarding is combinational from registered state plus the current forwarding inputs; zero-cycle latency; valid even when out_valid = 0.
REQ-026 Pipeline latency: one cycle from transfer in to out_valid; back-to-back throughput one instruction per cycle when no hazard or stall.

Reset
REQ-027 While rst_n = 0: out_valid = 0, all registered fields = 0, bubble_count = 0, taking effect immediately without a clock edge.
REQ-028 With the state at 0, data1/data2/store_data = 0 unless forwarding matches rs 0, which it never does.
REQ-029 Assertion mid-transfer discards the held instruction; the first capture occurs on the first rising edge after deassertion with in_valid high.

Structure
REQ-030 Shared package riscv_pkg holds XLEN, opcode constants (OP_ITYPE, OP_RTYPE, OP_LOAD, OP_STORE), funct3/funct7 encodings, and the ZERO constant.
REQ-031 One sub-module fwd_mux (index, registered data, both forwarding sources → forwarded value), instantiated for rs1 and rs2.

Verification
REQ-032 Capture: in_rs1_data = 5, in_imm = 7, use_imm = 1, funct3 = 0 → next cycle out_valid = 1, data1 = 5, data2 = 7, ALUOp = 0.
REQ-033 Priority: held rs1 = 3, exmem_rd = 3 with result 0xAA, memwb_rd = 3 with result 0xBB, both write-enables set → data1 = 0xAA; clear exmem_reg_write → data1 = 0xBB.
REQ-034 x0: held rs1 = 0, exmem_rd = 0, exmem_reg_write = 1 → data1 equals the registered value.
REQ-035 Load-use: held load with rd = 4, incoming rs2 = 4, use_imm = 0, out_ready = 1 → in_ready = 0, next cycle out_valid = 0 and bubble_count = 1, following cycle the instruction is captured.
REQ-036 Stall + flush: out_ready = 0 for 3 cycles → outputs stable, in_ready = 0; flush pulse → out_valid = 0 next cycle, bubble_count unchanged.
REQ-037 Async reset: rst_n dropped between edges while out_valid = 1 → out_valid = 0 before the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the held-instruction control record
// for the ID/EX pipeline register.
package riscv_pkg;

    localparam int XLEN = 32;

    // Register index x0: hard-wired zero, never a forwarding target.
    localparam logic [4:0] ZERO = 5'd0;

    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       use_imm;
        logic       reg_write;
        logic       mem_read;
        logic [6:0] optype;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, forwarding and execute-side signals of the ID/EX stage.
// slave is the stage's view; master is the surrounding pipeline's view.
interface id_ex_stage_if #(parameter int XLEN = riscv_pkg::XLEN);

    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;
    logic            in_reg_write;
    logic            in_mem_read;
    logic [6:0]      in_optype;
    logic [2:0]      in_funct3;
    logic [6:0]      in_funct7;

    logic [4:0]      exmem_rd;
    logic [4:0]      memwb_rd;
    logic            exmem_reg_write;
    logic            memwb_reg_write;
    logic [XLEN-1:0] exmem_result;
    logic [XLEN-1:0] memwb_result;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] store_data;
    logic [6:0]      optype;
    logic [2:0]      ALUOp;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic [15:0]     bubble_count;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
               in_use_imm, in_reg_write, in_mem_read, in_optype, in_funct3, in_funct7,
               exmem_rd, memwb_rd, exmem_reg_write, memwb_reg_write,
               exmem_result, memwb_result, flush, out_ready,
        output in_ready, out_valid, data1, data2, store_data, optype, ALUOp,
               funct7, rd, reg_write, mem_read, bubble_count
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
               in_use_imm, in_reg_write, in_mem_read, in_optype, in_funct3, in_funct7,
               exmem_rd, memwb_rd, exmem_reg_write, memwb_reg_write,
               exmem_result, memwb_result, flush, out_ready,
        input  in_ready, out_valid, data1, data2, store_data, optype, ALUOp,
               funct7, rd, reg_write, mem_read, bubble_count
    );

endinterface

// File: rtl/fwd_mux.sv
// Operand bypass: picks the youngest in-flight writer of a source register,
// falling back to the value read in decode.
module fwd_mux #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [4:0]      rs_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic [4:0]      exmem_rd_i,
    input  logic            exmem_we_i,
    input  logic [XLEN-1:0] exmem_result_i,
    input  logic [4:0]      memwb_rd_i,
    input  logic            memwb_we_i,
    input  logic [XLEN-1:0] memwb_result_i,
    output logic [XLEN-1:0] fwd_o
);
    import riscv_pkg::*;

    // EX/MEM is younger than MEM/WB, so it wins when both target rs.
    always_comb begin
        fwd_o = reg_data_i;
        if (exmem_we_i && exmem_rd_i == rs_i && rs_i != ZERO) begin
            fwd_o = exmem_result_i;
        end else if (memwb_we_i && memwb_rd_i == rs_i && rs_i != ZERO) begin
            fwd_o = memwb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ready/valid flow control, load-use bubble
// insertion, flush, and combinational operand forwarding on the held entry.
module id_ex_stage #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    import riscv_pkg::*;

    logic            valid_q, valid_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [15:0]     bubble_q, bubble_d;
    logic            hazard;
    logic            take;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Held load whose result the incoming instruction needs: it must wait a cycle.
    assign hazard = valid_q && ctrl_q.mem_read && ctrl_q.rd != ZERO &&
                    (ctrl_q.rd == bus.in_rs1 || (ctrl_q.rd == bus.in_rs2 && !bus.in_use_imm));
    assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard;
    assign take = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        bubble_d   = bubble_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (take) begin
            valid_d           = 1'b1;
            ctrl_d.rs1        = bus.in_rs1;
            ctrl_d.rs2        = bus.in_rs2;
            ctrl_d.rd         = bus.in_rd;
            ctrl_d.use_imm    = bus.in_use_imm;
            ctrl_d.reg_write  = bus.in_reg_write;
            ctrl_d.mem_read   = bus.in_mem_read;
            ctrl_d.optype     = bus.in_optype;
            ctrl_d.funct3     = bus.in_funct3;
            ctrl_d.funct7     = bus.in_funct7;
            rs1_data_d        = bus.in_rs1_data;
            rs2_data_d        = bus.in_rs2_data;
            imm_d             = bus.in_imm;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
            if (hazard) begin
                bubble_d = sat_inc16(bubble_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            bubble_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            bubble_q   <= bubble_d;
        end
    end

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_i           (ctrl_q.rs1),
        .reg_data_i     (rs1_data_q),
        .exmem_rd_i     (bus.exmem_rd),
        .exmem_we_i     (bus.exmem_reg_write),
        .exmem_result_i (bus.exmem_result),
        .memwb_rd_i     (bus.memwb_rd),
        .memwb_we_i     (bus.memwb_reg_write),
        .memwb_result_i (bus.memwb_result),
        .fwd_o          (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_i           (ctrl_q.rs2),
        .reg_data_i     (rs2_data_q),
        .exmem_rd_i     (bus.exmem_rd),
        .exmem_we_i     (bus.exmem_reg_write),
        .exmem_result_i (bus.exmem_result),
        .memwb_rd_i     (bus.memwb_rd),
        .memwb_we_i     (bus.memwb_reg_write),
        .memwb_result_i (bus.memwb_result),
        .fwd_o          (fwd_rs2)
    );

    assign bus.out_valid    = valid_q;
    assign bus.data1        = fwd_rs1;
    assign bus.data2        = ctrl_q.use_imm ? imm_q : fwd_rs2;
    assign bus.store_data   = fwd_rs2;
    assign bus.optype       = ctrl_q.optype;
    assign bus.ALUOp        = ctrl_q.funct3;
    assign bus.funct7       = ctrl_q.funct7;
    assign bus.rd           = ctrl_q.rd;
    assign bus.reg_write    = ctrl_q.reg_write;
    assign bus.mem_read     = ctrl_q.mem_read;
    assign bus.bubble_count = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, forwarding priority, x0,
// load-use bubble, stall, flush and asynchronous reset.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;

    id_ex_stage_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic use_imm, input logic rw, input logic mr,
                         input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.in_rs1 = rs1;      bus.in_rs2 = rs2;         bus.in_rd = rd;
        bus.in_rs1_data = d1;  bus.in_rs2_data = d2;     bus.in_imm = imm;
        bus.in_use_imm = use_imm; bus.in_reg_write = rw; bus.in_mem_read = mr;
        bus.in_optype = op;    bus.in_funct3 = f3;       bus.in_funct7 = f7;
    endtask

    task automatic clear_fwd();
        bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1'b0; bus.exmem_result = 32'd0;
        bus.memwb_rd = 5'd0; bus.memwb_reg_write = 1'b0; bus.memwb_result = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 7'd0);
        clear_fwd();
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_bubble", {16'd0, bus.bubble_count}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'h55;
        #1;
        chk("rst_data1_no_x0_fwd", bus.data1, 32'd0);
        chk("rst_store_data", bus.store_data, 32'd0);
        clear_fwd();
        rst_n = 1'b1;
        tick();

        // Capture with immediate operand
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        drive(5'd1, 5'd2, 5'd5, 32'd5, 32'd9, 32'd7, 1'b1, 1'b1, 1'b0, OP_ITYPE, F3_ADD, F7_BASE);
        tick();
        chk("cap_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("cap_data1", bus.data1, 32'd5);
        chk("cap_data2", bus.data2, 32'd7);
        chk("cap_aluop", {29'd0, bus.ALUOp}, 32'd0);
        chk("cap_rd", {27'd0, bus.rd}, 32'd5);
        chk("cap_store_data", bus.store_data, 32'd9);

        // Back-to-back R-type, then forwarding priority on the held entry
        drive(5'd3, 5'd6, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1, 1'b0, OP_RTYPE, F3_ADD, F7_SUB);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("b2b_funct7", {25'd0, bus.funct7}, {25'd0, F7_SUB});
        chk("b2b_data2_reg", bus.data2, 32'h22);
        bus.exmem_rd = 5'd3; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'hAA;
        bus.memwb_rd = 5'd3; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'hBB;
        #1;
        chk("prio_exmem", bus.data1, 32'hAA);
        bus.exmem_reg_write = 1'b0;
        #1;
        chk("prio_memwb", bus.data1, 32'hBB);
        bus.exmem_rd = 5'd6; bus.exmem_reg_write = 1'b1;
        #1;
        chk("fwd_rs2_data2", bus.data2, 32'hAA);
        chk("fwd_rs2_store", bus.store_data, 32'hAA);
        bus.exmem_reg_write = 1'b0;
        tick();
        chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("fwd_while_invalid", bus.data1, 32'hBB);
        clear_fwd();

        // x0 is never forwarded
        bus.in_valid = 1'b1;
        drive(5'd0, 5'd0, 5'd2, 32'h1234, 32'h0, 32'h10, 1'b1, 1'b1, 1'b0, OP_ITYPE, F3_ADD, F7_BASE);
        tick();
        bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'hAA;
        bus.memwb_rd = 5'd0; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'hBB;
        #1;
        chk("x0_data1", bus.data1, 32'h1234);
        clear_fwd();

        // Load-use: held load rd=4, incoming rs2=4 register operand
        drive(5'd1, 5'd0, 5'd4, 32'h0, 32'h0, 32'h8, 1'b1, 1'b1, 1'b1, OP_LOAD, F3_LW, F7_BASE);
        tick();
        chk("ld_mem_read", {31'd0, bus.mem_read}, 32'd1);
        drive(5'd5, 5'd4, 5'd9, 32'h40, 32'h50, 32'h0, 1'b0, 1'b1, 1'b0, OP_RTYPE, F3_ADD, F7_BASE);
        #1;
        chk("lu_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        chk("lu_bubble_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("lu_bubble_count", {16'd0, bus.bubble_count}, 32'd1);
        chk("lu_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("lu_capture_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("lu_capture_rd", {27'd0, bus.rd}, 32'd9);
        bus.memwb_rd = 5'd4; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'h77;
        #1;
        chk("lu_load_fwd", bus.data2, 32'h77);
        clear_fwd();

        // Stall three cycles with a new instruction waiting, then flush
        drive(5'd1, 5'd2, 5'd10, 32'h99, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, OP_RTYPE, F3_ADD, F7_BASE);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            tick();
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_rd", {27'd0, bus.rd}, 32'd9);
            chk("stall_data1", bus.data1, 32'h40);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_no_capture", {27'd0, bus.rd}, 32'd9);
        chk("flush_bubble", {16'd0, bus.bubble_count}, 32'd1);

        // Flush during a load-use hazard counts no bubble
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        drive(5'd1, 5'd0, 5'd4, 32'h0, 32'h0, 32'h8, 1'b1, 1'b1, 1'b1, OP_LOAD, F3_LW, F7_BASE);
        tick();
        drive(5'd4, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, OP_STORE, F3_SW, F7_BASE);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_hz_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_hz_bubble", {16'd0, bus.bubble_count}, 32'd1);

        // Asynchronous reset between edges while holding a valid entry
        drive(5'd2, 5'd3, 5'd12, 32'h5A, 32'h6B, 32'h0, 1'b0, 1'b1, 1'b0, OP_RTYPE, F3_ADD, F7_BASE);
        tick();
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_rd", {27'd0, bus.rd}, 32'd0);
        chk("arst_data1", bus.data1, 32'd0);
        chk("arst_bubble", {16'd0, bus.bubble_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("post_rst_capture", {31'd0, bus.out_valid}, 32'd1);
        chk("post_rst_data1", bus.data1, 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
